// File: rtl/cla_adder_pipe.sv
// Pipelined carry-look-ahead adder/subtractor: one WIDTH/SEGS-bit segment is resolved
// per stage, the segment carry is registered, and the pipeline freezes on backpressure.
module cla_adder_pipe #(
    parameter int WIDTH = 16,
    parameter int SEGS  = 4,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SW = WIDTH / SEGS;
    localparam int NG = SW / GROUP;

    // Carry into position lo+n, as a flat sum of products of g/p starting at lo with carry c0.
    function automatic logic la_carry(input logic [SW-1:0] g, input logic [SW-1:0] p,
                                      input logic c0, input int lo, input int n);
        logic carry_s;
        logic term_s;
        carry_s = 1'b0;
        for (int i = 0; i <= SW; i++) begin
            if (i <= n) begin
                if (i == 0) begin
                    term_s = c0;
                end else begin
                    term_s = g[lo+i-1];
                end
                for (int j = 0; j < SW; j++) begin
                    if ((j >= i) && (j < n)) begin
                        term_s = term_s & p[lo+j];
                    end else begin
                        term_s = term_s;
                    end
                end
                carry_s = carry_s | term_s;
            end else begin
                carry_s = carry_s;
            end
        end
        return carry_s;
    endfunction

    // One segment: group generate/propagate, then look-ahead across groups and within each group.
    function automatic logic [SW:0] seg_add(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                            input logic c0);
        logic [SW-1:0] g_s;
        logic [SW-1:0] p_s;
        logic [SW-1:0] gg_s;
        logic [SW-1:0] gp_s;
        logic [SW-1:0] s_s;
        logic          gc_s;
        g_s  = x & y;
        p_s  = x ^ y;
        gg_s = '0;
        gp_s = '0;
        s_s  = '0;
        for (int j = 0; j < NG; j++) begin
            gg_s[j] = la_carry(g_s, p_s, 1'b0, j * GROUP, GROUP);
            gp_s[j] = &p_s[j*GROUP +: GROUP];
        end
        for (int j = 0; j < NG; j++) begin
            gc_s = la_carry(gg_s, gp_s, c0, 0, j);
            for (int i = 0; i < GROUP; i++) begin
                s_s[j*GROUP+i] = p_s[j*GROUP+i] ^ la_carry(g_s, p_s, gc_s, j * GROUP, i);
            end
        end
        return {la_carry(gg_s, gp_s, c0, 0, NG), s_s};
    endfunction

    logic             v_r   [0:SEGS];
    logic             c_r   [0:SEGS];
    logic [WIDTH-1:0] sum_r [0:SEGS];
    logic [WIDTH-1:0] a_r   [0:SEGS-1];
    logic [WIDTH-1:0] b_r   [0:SEGS-1];
    logic             ovf_r;

    logic [WIDTH-1:0] sum_nx_s [1:SEGS];
    logic             c_nx_s   [1:SEGS];
    logic [SW:0]      seg_s;
    logic             ovf_nx_s;
    logic             stall_s;

    assign stall_s   = v_r[SEGS] & ~out_ready;
    assign in_ready  = ~stall_s;
    assign out_valid = v_r[SEGS];
    assign sum       = sum_r[SEGS];
    assign cout      = c_r[SEGS];
    assign ovf       = ovf_r;

    // Per-stage segment arithmetic and the overflow flag of the final stage.
    always_comb begin
        seg_s = '0;
        for (int k = 0; k < SEGS; k++) begin
            seg_s = seg_add(a_r[k][k*SW +: SW], b_r[k][k*SW +: SW], c_r[k]);
            sum_nx_s[k+1] = sum_r[k];
            sum_nx_s[k+1][k*SW +: SW] = seg_s[SW-1:0];
            c_nx_s[k+1] = seg_s[SW];
        end
        ovf_nx_s = (a_r[SEGS-1][WIDTH-1] == b_r[SEGS-1][WIDTH-1]) &&
                   (sum_nx_s[SEGS][WIDTH-1] != a_r[SEGS-1][WIDTH-1]);
    end

    // Pipeline registers: operands are conditioned at accept; everything freezes on a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= SEGS; k++) begin
                v_r[k]   <= 1'b0;
                c_r[k]   <= 1'b0;
                sum_r[k] <= '0;
            end
            for (int k = 0; k < SEGS; k++) begin
                a_r[k] <= '0;
                b_r[k] <= '0;
            end
            ovf_r <= 1'b0;
        end else if (!stall_s) begin
            v_r[0]   <= in_valid;
            a_r[0]   <= a;
            b_r[0]   <= sub ? ~b : b;
            c_r[0]   <= sub ^ cin;
            sum_r[0] <= '0;
            for (int k = 1; k <= SEGS; k++) begin
                v_r[k]   <= v_r[k-1];
                c_r[k]   <= c_nx_s[k];
                sum_r[k] <= sum_nx_s[k];
            end
            for (int k = 1; k < SEGS; k++) begin
                a_r[k] <= a_r[k-1];
                b_r[k] <= b_r[k-1];
            end
            ovf_r <= ovf_nx_s;
        end else begin
            ovf_r <= ovf_r;
        end
    end

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Self-checking bench for cla_adder_pipe: directed vector table, backpressure and reset
// sequences on a 16/4/4 instance, plus randomized sweeps of other widths against a model.
module tb_cla_adder_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_sw = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [15:0] a, b, sum;

    int n_chk = 0;
    int n_pass = 0;

    cla_adder_pipe #(.WIDTH(16), .SEGS(4), .GROUP(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endfunction

    // Reference: {ovf, cout, sum} from plain integer arithmetic on w-bit operands.
    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic c, input logic s, input int w);
        longint full, half, ux, uy, sx, sy, r, rs, ci;
        logic [33:0] res;
        full = longint'(1) << w;
        half = full / 2;
        ux = longint'(x) & (full - 1);
        uy = longint'(y) & (full - 1);
        sx = (ux >= half) ? ux - full : ux;
        sy = (uy >= half) ? uy - full : uy;
        ci = c ? 1 : 0;
        r  = s ? ux - uy - ci : ux + uy + ci;
        rs = s ? sx - sy - ci : sx + sy + ci;
        res[31:0] = 32'(r & (full - 1));
        res[32]   = s ? (r >= 0) : (r >= full);
        res[33]   = (rs >= half) || (rs < -half);
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat, then wait (bounded) for its result; lat counts edges from accept.
    task automatic send_one(input logic [15:0] x, input logic [15:0] y, input logic c,
                            input logic s, output int lat);
        a = x; b = y; cin = c; sub = s; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    typedef struct {
        logic [15:0] a, b;
        logic        cin, sub;
        logic [15:0] s;
        logic        co, ov;
    } vec_t;

    // Randomized sweeps of other geometries, each with its own scoreboard.
    for (genvar gi = 0; gi < 3; gi++) begin : g_sw
        localparam int W = (gi == 2) ? 8 : 32;
        localparam int S = (gi == 0) ? 1 : (gi == 1) ? 8 : 2;
        localparam int G = (gi == 2) ? 2 : 4;
        logic         iv_s, ir_s, ov_s, or_s, ci_s, sb_s, co_s, of_s;
        logic [W-1:0] a_s, b_s, s_s;
        bit           done_s = 1'b0;

        cla_adder_pipe #(.WIDTH(W), .SEGS(S), .GROUP(G)) u_dut (
            .clk(clk), .rst(rst_sw), .in_valid(iv_s), .in_ready(ir_s),
            .a(a_s), .b(b_s), .cin(ci_s), .sub(sb_s),
            .out_valid(ov_s), .out_ready(or_s),
            .sum(s_s), .cout(co_s), .ovf(of_s)
        );

        initial begin
            logic [33:0] eq[$];
            int aq[$];
            int stq[$];
            int cyc, stalls, sent, got;
            bit shown, acc, take, stl;
            logic [33:0] exp_v, act_v;
            iv_s = 1'b0; or_s = 1'b0; a_s = '0; b_s = '0; ci_s = 1'b0; sb_s = 1'b0;
            wait (!rst_sw);
            tick();
            cyc = 0; stalls = 0; sent = 0; got = 0; shown = 1'b0; exp_v = '0;
            while ((sent < 1000 || eq.size() > 0) && cyc < 8000) begin
                iv_s = (sent < 1000) && ($urandom_range(0, 3) != 0);
                a_s  = W'($urandom);
                b_s  = W'($urandom);
                if ($urandom_range(0, 7) == 0) a_s = '1;
                if ($urandom_range(0, 7) == 0) b_s = ($urandom_range(0, 1) == 0) ? '1 : '0;
                ci_s = 1'($urandom);
                sb_s = 1'($urandom);
                or_s = ($urandom_range(0, 2) != 0);
                #1;
                acc  = iv_s && ir_s;
                take = ov_s && or_s;
                stl  = ov_s && !or_s;
                if (take) begin
                    chk("sweep_expected_pending", 64'(eq.size() > 0), 64'd1);
                    if (eq.size() > 0) begin
                        act_v = {of_s, co_s, 32'(s_s)};
                        chk($sformatf("sweep%0d_result", gi), 64'(act_v), 64'(eq[0]));
                        void'(eq.pop_front());
                        void'(aq.pop_front());
                        void'(stq.pop_front());
                        got++;
                    end
                    shown = 1'b0;
                end
                if (acc) exp_v = model(32'(a_s), 32'(b_s), ci_s, sb_s, W);
                tick();
                cyc++;
                if (acc) begin
                    eq.push_back(exp_v);
                    aq.push_back(cyc);
                    stq.push_back(stalls);
                    sent++;
                end
                if (stl) stalls++;
                if (ov_s && !shown && eq.size() > 0) begin
                    chk($sformatf("sweep%0d_latency", gi),
                        64'(cyc - aq[0] - (stalls - stq[0])), 64'(S));
                    shown = 1'b1;
                end
            end
            chk($sformatf("sweep%0d_received", gi), 64'(got), 64'd1000);
            done_s = 1'b1;
        end
    end

    initial begin
        vec_t vt[12];
        logic [15:0] bpa[6], bpb[6];
        logic        bpc[6], bps[6];
        logic [33:0] bq[$];
        int lat, sent, got, hold, cyc, seen_cnt;
        bit seen, acc, take;

        vt[0]  = '{16'd1,     16'd1,     1'b0, 1'b0, 16'd2,      1'b0, 1'b0};
        vt[1]  = '{16'd20,    16'd32,    1'b0, 1'b0, 16'd52,     1'b0, 1'b0};
        vt[2]  = '{16'hFFFF,  16'd1,     1'b0, 1'b0, 16'h0000,   1'b1, 1'b0};
        vt[3]  = '{16'd200,   16'd50,    1'b1, 1'b0, 16'd251,    1'b0, 1'b0};
        vt[4]  = '{16'hFFFF,  16'hFFFF,  1'b1, 1'b0, 16'hFFFF,   1'b1, 1'b0};
        vt[5]  = '{16'd30000, 16'd30000, 1'b0, 1'b0, 16'hEA60,   1'b0, 1'b1};
        vt[6]  = '{16'h7FFF,  16'd1,     1'b0, 1'b0, 16'h8000,   1'b0, 1'b1};
        vt[7]  = '{16'd76,    16'd20,    1'b0, 1'b1, 16'd56,     1'b1, 1'b0};
        vt[8]  = '{16'd20,    16'd76,    1'b0, 1'b1, 16'hFFC8,   1'b0, 1'b0};
        vt[9]  = '{16'h8000,  16'd1,     1'b0, 1'b1, 16'h7FFF,   1'b1, 1'b1};
        vt[10] = '{16'd562,   16'd364,   1'b1, 1'b1, 16'd197,    1'b1, 1'b0};
        vt[11] = '{16'd0,     16'd0,     1'b1, 1'b1, 16'hFFFF,   1'b0, 1'b0};

        bpa = '{16'd562, 16'd100, 16'hFFFF, 16'd1000, 16'd5, 16'h7FFF};
        bpb = '{16'd364, 16'd23,  16'd1,    16'd1,    16'd7, 16'h7FFF};
        bpc = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        bps = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

        in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #12;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_sum", 64'(sum), 64'd0);
        chk("reset_cout", 64'(cout), 64'd0);
        chk("reset_ovf", 64'(ovf), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        rst_sw = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) begin
            send_one(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, lat);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
            chk($sformatf("vec%0d_sum", i), 64'(sum), 64'(vt[i].s));
            chk($sformatf("vec%0d_cout", i), 64'(cout), 64'(vt[i].co));
            chk($sformatf("vec%0d_ovf", i), 64'(ovf), 64'(vt[i].ov));
            tick();
        end

        // Back-to-back accepts: results on consecutive cycles.
        a = 16'd1; b = 16'd1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        tick();
        a = 16'd20; b = 16'd32;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("b2b_first_latency", 64'(lat), 64'd4);
        chk("b2b_first_sum", 64'(sum), 64'd2);
        tick();
        chk("b2b_second_valid", 64'(out_valid), 64'd1);
        chk("b2b_second_sum", 64'(sum), 64'd52);
        chk("b2b_second_flags", 64'({cout, ovf}), 64'd0);
        tick();

        // Stream of six beats with out_ready low for three cycles after the first result.
        sent = 0; got = 0; hold = 0; cyc = 0; seen = 1'b0; seen_cnt = 0;
        while (got < 6 && cyc < 60) begin
            in_valid = (sent < 6);
            if (sent < 6) begin
                a = bpa[sent]; b = bpb[sent]; cin = bpc[sent]; sub = bps[sent];
            end
            if (out_valid && !seen) begin
                seen = 1'b1;
                hold = 3;
            end
            out_ready = (hold == 0);
            #1;
            if (out_valid && !out_ready && bq.size() > 0) begin
                seen_cnt++;
                chk("bp_stall_in_ready", 64'(in_ready), 64'd0);
                chk("bp_stall_sum_held", 64'(sum), 64'(bq[0][15:0]));
            end
            acc  = in_valid && in_ready;
            take = out_valid && out_ready;
            if (take) begin
                chk("bp_expected_pending", 64'(bq.size() > 0), 64'd1);
                if (bq.size() > 0) begin
                    chk($sformatf("bp_beat%0d", got), 64'({ovf, cout, 16'd0, sum}),
                        64'(bq.pop_front()));
                    got++;
                end
            end
            if (acc) begin
                bq.push_back(model(32'(a), 32'(b), cin, sub, 16));
                sent++;
            end
            tick();
            cyc++;
            if (hold > 0) hold--;
        end
        chk("bp_beats_received", 64'(got), 64'd6);
        chk("bp_stall_cycles", 64'(seen_cnt), 64'd3);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();

        // Reset asserted between edges while the pipeline is stalled.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = 16'(i + 1); b = 16'(i + 2); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("rst_stall_reached", 64'(out_valid), 64'd1);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("rst_async_out_valid", 64'(out_valid), 64'd0);
        chk("rst_async_sum", 64'(sum), 64'd0);
        chk("rst_async_in_ready", 64'(in_ready), 64'd1);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        tick();
        seen_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen_cnt++;
            tick();
        end
        chk("rst_no_stale_results", 64'(seen_cnt), 64'd0);
        send_one(16'd5, 16'd5, 1'b0, 1'b0, lat);
        chk("rst_new_latency", 64'(lat), 64'd4);
        chk("rst_new_sum", 64'(sum), 64'd10);
        tick();

        cyc = 0;
        while (!(g_sw[0].done_s && g_sw[1].done_s && g_sw[2].done_s) && cyc < 20000) begin
            tick();
            cyc++;
        end
        chk("sweeps_finished",
            64'({g_sw[0].done_s, g_sw[1].done_s, g_sw[2].done_s}), 64'd7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
